// File: rtl/dds_top.sv
// DDS tone generator: phase accumulator, wave shaper, melody ROM, display.
// DDS_PWM_AUDIO_EN adds the PWM audio path and amp enable.
module dds_top #(
   parameter int TUNE_STEP   = 429,
   parameter int NOTE_CYCLES = 25_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  ctrl,
   input  logic [1:0]  ctrl_wav,
   input  logic        ctrl_dis,
   input  logic [2:0]  song_num,
   input  logic        auto_en,
   output logic [7:0]  wave_out,
   output logic [7:0]  dis_dig,
   output logic [13:0] dis_num,
   output logic        sd,
   output logic        audio_out,
   output logic        DAC_ILE,
   output logic        DAC_CS,
   output logic        DAC_WR1,
   output logic        DAC_WR2,
   output logic        DAC_XFER
);

   localparam int TW = (NOTE_CYCLES > 1) ? $clog2(NOTE_CYCLES) : 1;

   logic [31:0]   phase;
   logic [31:0]   step;
   logic [7:0]    e_code;
   logic [7:0]    note_code;
   logic [127:0]  row;
   logic [3:0]    idx;
   logic [3:0]    idx_nxt;
   logic [TW-1:0] timer;
   logic [TW-1:0] timer_nxt;
   logic [2:0]    song_prev;
   logic          auto_prev;
   logic          chg;
   logic [7:0]    p;
   logic [7:0]    wave_nxt;
   logic [13:0]   dis_nxt;
   logic [3:0]    wav_oh;

   function automatic logic [7:0] quarter(input logic [6:0] k);
      logic [7:0] q;
      case (k)
         7'd0:  q = 8'd128;  7'd1:  q = 8'd131;
         7'd2:  q = 8'd134;  7'd3:  q = 8'd137;
         7'd4:  q = 8'd140;  7'd5:  q = 8'd143;
         7'd6:  q = 8'd146;  7'd7:  q = 8'd149;
         7'd8:  q = 8'd152;  7'd9:  q = 8'd155;
         7'd10: q = 8'd158;  7'd11: q = 8'd162;
         7'd12: q = 8'd165;  7'd13: q = 8'd167;
         7'd14: q = 8'd170;  7'd15: q = 8'd173;
         7'd16: q = 8'd176;  7'd17: q = 8'd179;
         7'd18: q = 8'd182;  7'd19: q = 8'd185;
         7'd20: q = 8'd188;  7'd21: q = 8'd190;
         7'd22: q = 8'd193;  7'd23: q = 8'd196;
         7'd24: q = 8'd198;  7'd25: q = 8'd201;
         7'd26: q = 8'd203;  7'd27: q = 8'd206;
         7'd28: q = 8'd208;  7'd29: q = 8'd211;
         7'd30: q = 8'd213;  7'd31: q = 8'd215;
         7'd32: q = 8'd218;  7'd33: q = 8'd220;
         7'd34: q = 8'd222;  7'd35: q = 8'd224;
         7'd36: q = 8'd226;  7'd37: q = 8'd228;
         7'd38: q = 8'd230;  7'd39: q = 8'd232;
         7'd40: q = 8'd234;  7'd41: q = 8'd235;
         7'd42: q = 8'd237;  7'd43: q = 8'd238;
         7'd44: q = 8'd240;  7'd45: q = 8'd241;
         7'd46: q = 8'd243;  7'd47: q = 8'd244;
         7'd48: q = 8'd245;  7'd49: q = 8'd246;
         7'd50: q = 8'd248;  7'd51: q = 8'd249;
         7'd52: q = 8'd250;  7'd53: q = 8'd250;
         7'd54: q = 8'd251;  7'd55: q = 8'd252;
         7'd56: q = 8'd253;  7'd57: q = 8'd253;
         7'd58: q = 8'd254;  7'd59: q = 8'd254;
         7'd60: q = 8'd254;  7'd61: q = 8'd255;
         7'd62: q = 8'd255;  7'd63: q = 8'd255;
         default: q = 8'd255;
      endcase
      return q;
   endfunction

   // Second quadrant mirrors the first; the lower half is 255-q,
   // except p=128 where the exact value 127.5 rounds up to 128.
   function automatic logic [7:0] sine_lut(input logic [7:0] ph);
      logic [6:0] a;
      logic [6:0] k;
      logic [7:0] q;
      a = ph[6:0];
      k = a[6] ? (7'd0 - a) : a;
      q = quarter(k);
      if (!ph[7]) return q;
      else if (a == 7'd0) return 8'd128;
      else return 8'd255 - q;
   endfunction

   function automatic logic [127:0] song_row(input logic [2:0] s);
      logic [127:0] r;
      case (s)
         3'd0: r = {8'd26, 8'd26, 8'd39, 8'd39, 8'd44, 8'd44, 8'd39, 8'd0,
                    8'd35, 8'd35, 8'd33, 8'd33, 8'd29, 8'd29, 8'd26, 8'd0};
         3'd1: r = {8'd33, 8'd29, 8'd26, 8'd29, 8'd33, 8'd33, 8'd33, 8'd0,
                    8'd29, 8'd29, 8'd29, 8'd0,  8'd33, 8'd39, 8'd39, 8'd0};
         3'd2: r = {8'd26, 8'd29, 8'd33, 8'd26, 8'd26, 8'd29, 8'd33, 8'd26,
                    8'd33, 8'd35, 8'd39, 8'd0,  8'd33, 8'd35, 8'd39, 8'd0};
         3'd3: r = {8'd39, 8'd44, 8'd39, 8'd35, 8'd33, 8'd26, 8'd0,  8'd0,
                    8'd39, 8'd44, 8'd39, 8'd35, 8'd33, 8'd26, 8'd0,  8'd0};
         3'd4: r = {8'd52, 8'd49, 8'd44, 8'd39, 8'd35, 8'd33, 8'd29, 8'd26,
                    8'd29, 8'd33, 8'd35, 8'd39, 8'd44, 8'd49, 8'd52, 8'd0};
         3'd5: r = {8'd33, 8'd33, 8'd35, 8'd39, 8'd39, 8'd35, 8'd33, 8'd29,
                    8'd26, 8'd26, 8'd29, 8'd33, 8'd33, 8'd29, 8'd29, 8'd0};
         3'd6: r = {8'd26, 8'd33, 8'd39, 8'd52, 8'd39, 8'd33, 8'd26, 8'd0,
                    8'd29, 8'd35, 8'd44, 8'd52, 8'd44, 8'd35, 8'd29, 8'd0};
         default:
               r = {8'd44, 8'd0,  8'd44, 8'd0,  8'd39, 8'd0,  8'd39, 8'd0,
                    8'd35, 8'd35, 8'd33, 8'd33, 8'd29, 8'd29, 8'd26, 8'd0};
      endcase
      return r;
   endfunction

   // Note code lookup; index 0 is the leftmost literal of each row.
   always_comb begin
      row       = song_row(song_num);
      note_code = row[{~idx, 3'b000} +: 8];
      e_code    = auto_en ? note_code : ctrl;
      step      = 32'(e_code) * 32'(TUNE_STEP);
      p         = phase[31:24];
      wav_oh    = 4'b0001 << ctrl_wav;
   end

   // Wave shaper selected by ctrl_wav.
   always_comb begin
      wave_nxt = 8'h80;
      unique case (ctrl_wav)
         2'd0: wave_nxt = sine_lut(p);
         2'd1: wave_nxt = p[7] ? 8'h00 : 8'hFF;
         2'd2: wave_nxt = p[7] ? ~{p[6:0], 1'b0} : {p[6:0], 1'b0};
         2'd3: wave_nxt = p;
      endcase
   end

   // Melody sequencer next state; restarts on song change or auto entry.
   always_comb begin
      chg       = auto_en && (!auto_prev || (song_num != song_prev));
      idx_nxt   = idx;
      timer_nxt = timer;
      if (!auto_en || chg) begin
         idx_nxt   = 4'd0;
         timer_nxt = '0;
      end else if (timer == TW'(NOTE_CYCLES - 1)) begin
         idx_nxt   = idx + 4'd1;
         timer_nxt = '0;
      end else begin
         timer_nxt = timer + TW'(1);
      end
   end

   // Display value uses the post-update note index.
   always_comb begin
      dis_nxt = 14'(e_code) * 14'd10;
      if (ctrl_dis)
         dis_nxt = 14'(song_num) * 14'd100 + 14'(idx_nxt);
   end

   // Phase accumulator and registered DAC sample.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         phase    <= '0;
         wave_out <= 8'h80;
      end else begin
         phase    <= phase + step;
         wave_out <= wave_nxt;
      end
   end

   // Melody index, note timer and change-detect history.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idx       <= 4'd0;
         timer     <= '0;
         song_prev <= 3'd0;
         auto_prev <= 1'b0;
      end else begin
         idx       <= idx_nxt;
         timer     <= timer_nxt;
         song_prev <= song_num;
         auto_prev <= auto_en;
      end
   end

   // Display registers and DAC chip select.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dis_num <= '0;
         dis_dig <= '0;
         DAC_CS  <= 1'b1;
      end else begin
         dis_num <= dis_nxt;
         dis_dig <= {auto_en, song_num, wav_oh};
         DAC_CS  <= 1'b0;
      end
   end

   assign DAC_ILE  = 1'b1;
   assign DAC_WR1  = 1'b0;
   assign DAC_WR2  = 1'b0;
   assign DAC_XFER = 1'b0;

`ifdef DDS_PWM_AUDIO_EN
   logic [7:0] pwm_cnt;

   // Free-running PWM compare against the current sample.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pwm_cnt   <= 8'd0;
         audio_out <= 1'b0;
         sd        <= 1'b0;
      end else begin
         pwm_cnt   <= pwm_cnt + 8'd1;
         audio_out <= (pwm_cnt < wave_out);
         sd        <= 1'b1;
      end
   end
`else
   assign audio_out = 1'b0;
   assign sd        = 1'b0;
`endif

endmodule

// File: tb/tb_dds_top.sv
// Directed bench for dds_top: reset, waveforms, melody, PWM, async reset.
module tb_dds_top;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  ctrl;
   logic [1:0]  ctrl_wav;
   logic        ctrl_dis;
   logic [2:0]  song_num;
   logic        auto_en;
   logic [7:0]  wave_out;
   logic [7:0]  dis_dig;
   logic [13:0] dis_num;
   logic        sd;
   logic        audio_out;
   logic        DAC_ILE, DAC_CS, DAC_WR1, DAC_WR2, DAC_XFER;

   int checks = 0;
   int errors = 0;
   logic [31:0] ph = '0;

`ifdef DDS_PWM_AUDIO_EN
   localparam logic SD_ON = 1'b1;
   localparam int   DUTY  = 64;
`else
   localparam logic SD_ON = 1'b0;
   localparam int   DUTY  = 0;
`endif

   dds_top #(.TUNE_STEP(429), .NOTE_CYCLES(100)) dut (
      .clk(clk), .rst(rst), .ctrl(ctrl), .ctrl_wav(ctrl_wav),
      .ctrl_dis(ctrl_dis), .song_num(song_num), .auto_en(auto_en),
      .wave_out(wave_out), .dis_dig(dis_dig), .dis_num(dis_num),
      .sd(sd), .audio_out(audio_out),
      .DAC_ILE(DAC_ILE), .DAC_CS(DAC_CS), .DAC_WR1(DAC_WR1),
      .DAC_WR2(DAC_WR2), .DAC_XFER(DAC_XFER)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      if (rst) ph = ph + 32'(ctrl) * 32'd429;
      @(negedge clk);
   endtask

   task automatic run_to(input logic [7:0] code, input logic [7:0] target);
      int n = 0;
      ctrl = code;
      while (ph[31:24] !== target && n < 50000) begin
         tick();
         n++;
      end
      ctrl = 8'd0;
      checks++;
      if (n >= 50000) begin
         errors++;
         $display("FAIL run_to timeout: target p=%0d not reached", target);
      end
      tick();
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b0; ctrl = 0; ctrl_wav = 0; ctrl_dis = 0;
      song_num = 0; auto_en = 0;
      #12;
      checks++;
      if (wave_out !== 8'h80) begin
         errors++; $display("FAIL rst_wave: got %h want 80", wave_out);
      end
      checks++;
      if ({dis_num, dis_dig} !== 22'd0) begin
         errors++; $display("FAIL rst_dis: got %0d/%h want 0/00", dis_num, dis_dig);
      end
      checks++;
      if ({sd, audio_out, DAC_CS} !== 3'b001) begin
         errors++; $display("FAIL rst_ctl: got %b want 001", {sd, audio_out, DAC_CS});
      end
      @(negedge clk);
      rst = 1'b1;
      ph = '0;
      tick();
      checks++;
      if ({DAC_ILE, DAC_CS, DAC_WR1, DAC_WR2, DAC_XFER} !== 5'b10000) begin
         errors++;
         $display("FAIL dac_pass: got %b want 10000",
                  {DAC_ILE, DAC_CS, DAC_WR1, DAC_WR2, DAC_XFER});
      end
      checks++;
      if (sd !== SD_ON) begin
         errors++; $display("FAIL sd_on: got %b want %b", sd, SD_ON);
      end
      checks++;
      if (dis_dig !== 8'h01) begin
         errors++; $display("FAIL dig_sine: got %h want 01", dis_dig);
      end
   endtask

   task automatic test_sine_zero();
      ctrl = 0; ctrl_wav = 0;
      repeat (20) tick();
      checks++;
      if (wave_out !== 8'h80 || dis_num !== 14'd0) begin
         errors++; $display("FAIL e0_hold: got %h/%0d want 80/0", wave_out, dis_num);
      end
   endtask

   task automatic test_triangle();
      ctrl_wav = 2; ctrl = 255;
      tick();
      checks++;
      if (dis_num !== 14'd2550 || dis_dig !== 8'h04) begin
         errors++; $display("FAIL dis_max: got %0d/%h want 2550/04", dis_num, dis_dig);
      end
      run_to(255, 64);
      checks++;
      if (wave_out !== 8'd128) begin
         errors++; $display("FAIL tri_p64: got %0d want 128", wave_out);
      end
      ctrl_wav = 1; tick();
      checks++;
      if (wave_out !== 8'hFF) begin
         errors++; $display("FAIL sq_p64: got %h want FF", wave_out);
      end
      ctrl_wav = 0; tick();
      checks++;
      if (wave_out !== 8'd255) begin
         errors++; $display("FAIL sin_p64: got %0d want 255", wave_out);
      end
      ctrl_wav = 3; tick();
      checks++;
      if (wave_out !== 8'h40 || dis_num !== 14'd0) begin
         errors++; $display("FAIL saw_p64: got %h/%0d want 40/0", wave_out, dis_num);
      end
   endtask

   task automatic test_pwm();
      int cnt = 0;
      repeat (3) tick();
      repeat (256) begin
         tick();
         if (audio_out === 1'b1) cnt++;
      end
      checks++;
      if (cnt != DUTY) begin
         errors++; $display("FAIL pwm_duty: got %0d want %0d", cnt, DUTY);
      end
   endtask

   task automatic test_sine_points();
      ctrl_wav = 0;
      run_to(255, 160);
      checks++;
      if (wave_out !== 8'd37) begin
         errors++; $display("FAIL sin_p160: got %0d want 37", wave_out);
      end
      ctrl_wav = 2; tick();
      checks++;
      if (wave_out !== 8'hBF) begin
         errors++; $display("FAIL tri_p160: got %h want BF", wave_out);
      end
      ctrl_wav = 0;
      run_to(255, 192);
      checks++;
      if (wave_out !== 8'd0) begin
         errors++; $display("FAIL sin_p192: got %0d want 0", wave_out);
      end
   endtask

   task automatic test_square_wrap();
      ctrl_wav = 1; tick();
      checks++;
      if (wave_out !== 8'h00) begin
         errors++; $display("FAIL sq_p192: got %h want 00", wave_out);
      end
      ctrl = 120; tick();
      checks++;
      if (dis_num !== 14'd1200) begin
         errors++; $display("FAIL dis_1200: got %0d want 1200", dis_num);
      end
      run_to(120, 0);
      checks++;
      if (wave_out !== 8'hFF) begin
         errors++; $display("FAIL sq_wrap: got %h want FF", wave_out);
      end
      ctrl_wav = 0; tick();
      checks++;
      if (wave_out !== 8'd128) begin
         errors++; $display("FAIL sin_p0: got %0d want 128", wave_out);
      end
   endtask

   task automatic test_melody();
      ctrl_dis = 1; song_num = 4; auto_en = 1;
      tick();
      checks++;
      if (dis_num !== 14'd400) begin
         errors++; $display("FAIL mel_start: got %0d want 400", dis_num);
      end
      repeat (99) tick();
      checks++;
      if (dis_num !== 14'd400) begin
         errors++; $display("FAIL mel_hold: got %0d want 400", dis_num);
      end
      tick();
      checks++;
      if (dis_num !== 14'd401) begin
         errors++; $display("FAIL mel_n1: got %0d want 401", dis_num);
      end
      for (int i = 2; i < 17; i++) begin
         repeat (100) tick();
         checks++;
         if (dis_num !== 14'(400 + (i % 16))) begin
            errors++;
            $display("FAIL mel_seq: got %0d want %0d", dis_num, 400 + (i % 16));
         end
      end
      repeat (50) tick();
      song_num = 2; tick();
      checks++;
      if (dis_num !== 14'd200) begin
         errors++; $display("FAIL mel_song: got %0d want 200", dis_num);
      end
      ctrl_dis = 0; tick();
      checks++;
      if (dis_num !== 14'd260 || dis_dig !== 8'hA1) begin
         errors++; $display("FAIL mel_freq: got %0d/%h want 260/A1", dis_num, dis_dig);
      end
      auto_en = 0; ctrl_dis = 1; tick();
      checks++;
      if (dis_num !== 14'd200) begin
         errors++; $display("FAIL man_song: got %0d want 200", dis_num);
      end
      ctrl = 7; ctrl_dis = 0; tick();
      checks++;
      if (dis_num !== 14'd70) begin
         errors++; $display("FAIL man_freq: got %0d want 70", dis_num);
      end
      repeat (30) tick();
      auto_en = 1; ctrl_dis = 1; tick();
      checks++;
      if (dis_num !== 14'd200) begin
         errors++; $display("FAIL auto_reent: got %0d want 200", dis_num);
      end
   endtask

   task automatic test_async_reset();
      ctrl_wav = 1;
      repeat (5) tick();
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if (wave_out !== 8'h80 || DAC_CS !== 1'b1 || sd !== 1'b0) begin
         errors++;
         $display("FAIL async_rst: got %h/%b/%b want 80/1/0", wave_out, DAC_CS, sd);
      end
      checks++;
      if (dis_num !== 14'd0 || audio_out !== 1'b0) begin
         errors++; $display("FAIL async_dis: got %0d/%b want 0/0", dis_num, audio_out);
      end
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      test_reset();
      test_sine_zero();
      test_triangle();
      test_pwm();
      test_sine_points();
      test_square_wrap();
      test_melody();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
